// File: rtl/seg_pkg.sv
// seg_pkg: active-high glyph constants (bit0 = a .. bit6 = g), nibble decoder
// and scan-index width helper shared by seven_segment_scanner and its timer.
package seg_pkg;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: per-slot prescaler, scan index and frame-start strobe.
// idx_o/active_o/load_o are next-state values so the top can register pins with 1 clk latency.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int REFRESH_DIV = 100000,
    localparam int IW = idx_width(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          load_o,
    output logic          active_o,
    output logic [IW-1:0] idx_o,
    output logic          frame_start_o
);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q;
    logic          active_q, tick;

    // Until the first tick the display is dark; that tick starts frame 0 at digit 0.
    always_comb begin
        tick = presc_q == PW'(REFRESH_DIV - 1);
        presc_d = tick ? '0 : presc_q + 1'b1;
        load_o = tick && (!active_q || idx_q == IW'(NUM_DIGITS - 1));
        idx_o = load_o ? '0 : tick ? idx_q + 1'b1 : idx_q;
        active_o = active_q || tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q <= '0;
            active_q <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q <= idx_o;
            active_q <= active_o;
            frame_start_o <= load_o;
        end
    end
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed 7-segment driver with per-frame capture, hex glyphs,
// leading-zero blanking and output polarity; define SEG_BRIGHTNESS_EN for PWM dimming via brillo.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ANODE_ACTIVE_LOW = 1,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter int BRIGHT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] codigo_BCD,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0]     brillo,
`endif
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic [6:0]              catodo,
    output logic                    punto,
    output logic                    frame_start
);
    localparam int IW = idx_width(NUM_DIGITS);

    logic                    load, active, pwm_ok, allz, blank, blz_q, blz_d, pt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] code_q, code_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d, lead_zero, an;
    logic [3:0]              nib;
    logic [6:0]              seg;

    seg_scan_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .load_o(load),
        .active_o(active),
        .idx_o(idx),
        .frame_start_o(frame_start)
    );

`ifdef SEG_BRIGHTNESS_EN
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    assign pwm_d = pwm_q + 1'b1;
    assign pwm_ok = pwm_d < brillo;
    always_ff @(posedge clk) pwm_q <= reset ? '0 : pwm_d;
`else
    assign pwm_ok = BRIGHT_W > 0;
`endif

    // Decode from the shadow values being loaded this edge so frame 0 appears right after its tick.
    always_comb begin
        code_d = load ? codigo_BCD : code_q;
        dp_d = load ? dp : dp_q;
        blz_d = load ? blank_lz : blz_q;
        allz = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            allz = allz && code_d[4*j +: 4] == 4'd0;
            lead_zero[j] = allz;
        end
        nib = code_d[4*idx +: 4];
        blank = blz_d && idx != '0 && lead_zero[idx];
        an = (active && pwm_ok) ? (NUM_DIGITS'(1) << idx) : '0;
        seg = (active && !blank) ? hex_to_seg(nib) : SEG_BLANK;
        pt = active && dp_d[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= '0;
            dp_q <= '0;
            blz_q <= 1'b0;
            anodo <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
            catodo <= {7{SEG_ACTIVE_LOW}};
            punto <= SEG_ACTIVE_LOW;
        end else begin
            code_q <= code_d;
            dp_q <= dp_d;
            blz_q <= blz_d;
            anodo <= an ^ {NUM_DIGITS{ANODE_ACTIVE_LOW}};
            catodo <= seg ^ {7{SEG_ACTIVE_LOW}};
            punto <= pt ^ SEG_ACTIVE_LOW;
        end
    end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: randomized and directed checks against a frame/slot timing model.
module tb_seven_segment_scanner;
    localparam int N = 4;
    localparam int DIV = 4;
    localparam int BW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] codigo_BCD = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  anodo;
    logic [6:0]  catodo;
    logic        punto, frame_start;
`ifdef SEG_BRIGHTNESS_EN
    logic [BW-1:0] brillo = '1;
`endif

    int checks = 0;
    int errors = 0;

    int          t;
    logic [15:0] fv;
    logic [3:0]  fdp;
    logic        fblz;
    logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  cat_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(DIV),
        .ANODE_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1),
        .BRIGHT_W(BW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .codigo_BCD(codigo_BCD),
        .dp(dp),
        .blank_lz(blank_lz),
`ifdef SEG_BRIGHTNESS_EN
        .brillo(brillo),
`endif
        .anodo(anodo),
        .catodo(catodo),
        .punto(punto),
        .frame_start(frame_start)
    );

    // t = edges since reset; slot s = t/DIV, s>=1 shows digit (s-1)%N; a frame is captured when its digit-0 slot begins.
    always @(posedge clk) begin
        if (reset) begin
            t <= 0;
            fv <= '0;
            fdp <= '0;
            fblz <= 1'b0;
        end else begin
            t <= t + 1;
            if ((t + 1) % DIV == 0 && ((t + 1) / DIV - 1) % N == 0) begin
                fv <= codigo_BCD;
                fdp <= dp;
                fblz <= blank_lz;
            end
        end
    end

    function automatic logic [12:0] exp_pins();
        logic [3:0] an = '0;
        logic [6:0] sg = '0;
        logic pt = 1'b0;
        logic fs = 1'b0;
        int d;
        if (t >= DIV) begin
            d = (t / DIV - 1) % N;
            an = 4'(1 << d);
            if (!(fblz && d > 0 && (fv >> (4 * d)) == 16'd0))
                sg = glyph[fv[4*d +: 4]];
            pt = fdp[d];
            fs = (t % DIV == 0) && d == 0;
`ifdef SEG_BRIGHTNESS_EN
            if ((t % (1 << BW)) >= int'(brillo))
                an = '0;
`endif
        end
        return {~an, ~sg, ~pt, fs};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        codigo_BCD = 16'h1234;
        dp = '0;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({anodo, catodo, punto, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got %b want %b", {anodo, catodo, punto, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({anodo, frame_start} !== {4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_dark cyc %0d got anodo %b fs %b want 1111 0", i, anodo, frame_start);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_an;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            want_an = an_seq[i / 4];
`ifdef SEG_BRIGHTNESS_EN
            if (i % 4 >= int'(brillo)) want_an = 4'hF;
`endif
            checks++;
            if ({anodo, catodo, frame_start} !== {want_an, cat_1234[i / 4], i == 0}) begin
                errors++;
                $display("FAIL scan_1234 cyc %0d got %b %h %b want %b %h %b", i, anodo, catodo, frame_start,
                         want_an, cat_1234[i / 4], i == 0);
            end
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                errors++;
                $display("FAIL scan_model cyc %0d got %b want %b", i, {anodo, catodo, punto, frame_start}, exp_pins());
            end
        end
    endtask

    task automatic test_hold_midframe();
        int n = 0;
        codigo_BCD = 16'h1234;
        while (anodo[1] !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (anodo[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait got anodo %b want digit 1 active", anodo);
        end
        codigo_BCD = 16'hABCD;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                errors++;
                $display("FAIL hold_model cyc %0d got %b want %b", i, {anodo, catodo, punto, frame_start}, exp_pins());
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0100};
        blank_lz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            codigo_BCD = vals[v];
            for (int i = 0; i < 36; i++) begin
                @(negedge clk);
                checks++;
                if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                    errors++;
                    $display("FAIL blank_%h cyc %0d got %b want %b", vals[v], i, {anodo, catodo, punto, frame_start}, exp_pins());
                end
            end
        end
    endtask

    task automatic test_dp_blanked();
        int lit = 0;
        blank_lz = 1'b1;
        dp = 4'b0100;
        codigo_BCD = 16'h0007;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (punto === 1'b0) lit++;
            checks++;
            if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                errors++;
                $display("FAIL dp_blank cyc %0d got %b want %b", i, {anodo, catodo, punto, frame_start}, exp_pins());
            end
        end
        checks++;
        if (lit != DIV) begin
            errors++;
            $display("FAIL dp_blank_count got %0d lit cycles want %0d", lit, DIV);
        end
        dp = '0;
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        codigo_BCD = 16'h9876;
        dp = 4'hF;
        while (anodo !== 4'b1011 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (anodo !== 4'b1011) begin
            errors++;
            $display("FAIL rst_mid_wait got anodo %b want 1011", anodo);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({anodo, catodo, punto, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_dark got %b want %b", {anodo, catodo, punto, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (anodo !== 4'b1110 && n < 16);
        checks++;
        if (n != DIV) begin
            errors++;
            $display("FAIL rst_mid_restart got %0d clk want %0d", n, DIV);
        end
        checks++;
        if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
            errors++;
            $display("FAIL rst_mid_first got %b want %b", {anodo, catodo, punto, frame_start}, exp_pins());
        end
        dp = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, {anodo, catodo, punto, frame_start}, exp_pins());
            end
            if ($urandom_range(0, 5) == 0) begin
                codigo_BCD = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp = 4'($urandom);
                blank_lz = 1'($urandom);
            end
        end
    endtask

`ifdef SEG_BRIGHTNESS_EN
    task automatic test_brightness();
        int on;
        codigo_BCD = 16'h5A5A;
        for (int b = 0; b < 4; b++) begin
            brillo = BW'(b);
            repeat (16) @(negedge clk);
            on = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (anodo !== 4'hF) on++;
                checks++;
                if ({anodo, catodo, punto, frame_start} !== exp_pins()) begin
                    errors++;
                    $display("FAIL bright_%0d cyc %0d got %b want %b", b, i, {anodo, catodo, punto, frame_start}, exp_pins());
                end
            end
            checks++;
            if (on != 4 * b) begin
                errors++;
                $display("FAIL bright_duty_%0d got %0d on cycles want %0d", b, on, 4 * b);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_hold_midframe();
        test_blanking();
        test_dp_blanked();
        test_reset_midframe();
        test_random();
`ifdef SEG_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
